// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: issue, credit and in-order result buffering around an add pipe.
// Build option FP_ADD_SEQ_ILLEGAL_EN: illegal opcodes complete with out_err set.
module fp_add_sequencer #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 5,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic [3:0]       pipe_opcode,
  input  logic [WIDTH-1:0] pipe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic             fire;
  logic             pop;
  logic             wr;
  logic             nonempty;
  logic [LAT-1:0]   v;
  logic [TAG_W-1:0] tag_sr [LAT];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [WIDTH-1:0] wr_res;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [CW-1:0]    credits;

  assign pipe_a      = in_a;
  assign pipe_b      = in_b;
  assign pipe_opcode = in_opcode;

  assign fire     = in_valid & in_ready;
  assign nonempty = count != '0;
  assign pop      = nonempty & out_ready;
  assign wr       = v[LAT-1];

  assign out_valid  = nonempty;
  assign out_result = nonempty ? res_mem[rptr] : '0;
  assign out_tag    = nonempty ? tag_mem[rptr] : '0;
  assign busy       = (v != '0) | nonempty;

  // credits: every op fired and not yet popped holds one FIFO slot
  always_comb begin
    credits = CW'(count);
    for (int i = 0; i < LAT; i++) begin
      credits = credits + CW'(v[i]);
    end
  end

  assign in_ready = rst_n & (credits < CW'(DEPTH));

  // in-flight valid/tag tracking aligned with the add pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      v[0]      <= fire;
      tag_sr[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        v[i]      <= v[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

`ifdef FP_ADD_SEQ_ILLEGAL_EN
  logic             illegal;
  logic [LAT-1:0]   err_sr;
  logic [DEPTH-1:0] err_mem;

  assign illegal = !(in_opcode inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9});

  // error flag travels alongside the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sr <= '0;
    end else begin
      err_sr[0] <= illegal;
      for (int i = 1; i < LAT; i++) begin
        err_sr[i] <= err_sr[i-1];
      end
    end
  end

  assign wr_res  = err_sr[LAT-1] ? '0 : pipe_result;
  assign out_err = nonempty & err_mem[rptr];

  // error bit storage for buffered results
  always_ff @(posedge clk) begin
    if (wr) begin
      err_mem[wptr] <= err_sr[LAT-1];
    end
  end
`else
  assign wr_res  = pipe_result;
  assign out_err = 1'b0;
`endif

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (wr) begin
      res_mem[wptr] <= wr_res;
      tag_mem[wptr] <= tag_sr[LAT-1];
    end
  end

endmodule
